// File: rtl/ccg_exhaustive_tester.sv
// ccg_exhaustive_tester
// Sweeps every input vector of a generated combinational circuit and holds each
// vector for SETTLE cycles before sampling the response. Each response is streamed
// out as a valid/ready beat and folded into a MISR signature. At the end of the
// sweep the signature is compared against a golden value.
module ccg_exhaustive_tester #(
  parameter int               N_IN   = 3,
  parameter int               N_OUT  = 15,
  parameter int               SETTLE = 2,
  parameter logic [N_OUT-1:0] POLY   = 15'h4001,
  parameter logic [N_OUT-1:0] SEED   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_OUT-1:0] golden,
  output logic [N_IN-1:0]  x,
  input  logic [N_OUT-1:0] f,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N_IN-1:0]  rsp_vec,
  output logic [N_OUT-1:0] rsp_data,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] signature,
  output logic             pass
);

  // The settle counter needs at least one bit, even when SETTLE is 1
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] X_LAST = {N_IN{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    CAPTURE,
    WAIT_RSP,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  x_q, x_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [N_OUT-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [N_OUT-1:0] sig_q, sig_d;
  logic             busy_q, busy_d;
  logic             pass_q, pass_d;

  // State and datapath registers; reset aborts any sweep in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sig_q   <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
    end
  end

  // Sweep sequencing: drive, settle, capture into the MISR, hand off the beat
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    data_d  = data_q;
    valid_d = valid_q;
    sig_d   = sig_q;
    busy_d  = busy_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = '0;
          cnt_d   = '0;
          sig_d   = SEED;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CAPTURE: begin
        data_d  = f;
        vec_d   = x_q;
        valid_d = 1'b1;
        sig_d   = {sig_q[N_OUT-2:0], 1'b0} ^ (sig_q[N_OUT-1] ? POLY : '0) ^ f;
        state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          if (x_q == X_LAST) begin
            state_d = DONE;
          end else begin
            x_d     = x_q + N_IN'(1);
            cnt_d   = '0;
            state_d = DRIVE;
          end
        end
      end
      DONE: begin
        pass_d  = (sig_q == golden);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign x         = x_q;
  assign rsp_valid = valid_q;
  assign rsp_vec   = vec_q;
  assign rsp_data  = data_q;
  assign busy      = busy_q;
  assign done      = (state_q == DONE);
  assign signature = sig_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_ccg_exhaustive_tester.sv
// tb_ccg_exhaustive_tester
// Randomized and directed sweeps against a behavioural model of the tester:
// expected beats come from a per-vector response table, the expected signature
// from folding that table with the MISR rule, and the expected sweep length from
// the per-vector latency plus any cycles stalled by the sink.
module tb_ccg_exhaustive_tester;

  localparam int               NV   = 8;
  localparam int               S0   = 2;
  localparam int               S1   = 1;
  localparam logic [14:0]      POLY = 15'h4001;
  localparam logic [14:0]      SEED = 15'h0000;

  logic        clk;
  logic        rst_n;
  logic        start, start1;
  logic [14:0] golden;
  logic [2:0]  x, x1;
  logic [14:0] f, f1;
  logic        rsp_valid, rsp_valid1;
  logic        rsp_ready, rsp_ready1;
  logic [2:0]  rsp_vec, rsp_vec1;
  logic [14:0] rsp_data, rsp_data1;
  logic        busy, busy1, done, done1, pass, pass1;
  logic [14:0] signature, signature1;

  logic [14:0] fTable [NV];

  int total = 0;
  int bad   = 0;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The circuit under test is modelled as a lookup table on the applied vector
  assign f  = fTable[x];
  assign f1 = {12'b0, x1};

  ccg_exhaustive_tester #(.N_IN(3), .N_OUT(15), .SETTLE(S0), .POLY(POLY), .SEED(SEED)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .golden(golden), .x(x), .f(f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vec(rsp_vec), .rsp_data(rsp_data),
    .busy(busy), .done(done), .signature(signature), .pass(pass)
  );

  ccg_exhaustive_tester #(.N_IN(3), .N_OUT(15), .SETTLE(S1), .POLY(POLY), .SEED(SEED)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .golden(15'h0000), .x(x1), .f(f1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_vec(rsp_vec1), .rsp_data(rsp_data1),
    .busy(busy1), .done(done1), .signature(signature1), .pass(pass1)
  );

  // Count one comparison and report it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference MISR: fold the response table for vectors 0..NV-1 in order
  function automatic logic [14:0] modelSig();
    int s;
    s = int'(SEED);
    for (int v = 0; v < NV; v++) begin
      s = ((s * 2) % 32768) ^ (((s / 16384) % 2 == 1) ? int'(POLY) : 0) ^ int'(fTable[v]);
    end
    return s[14:0];
  endfunction

  // One full sweep on the SETTLE=2 instance.
  // readyMode 0: always ready, 1: random ready, 2: stall beat 2 for five cycles.
  task automatic applyStimulus(input string name, input int readyMode,
                               input logic [14:0] gold, input bit midStart);
    int          cyc;
    int          beats;
    int          stalls;
    int          beat2Stall;
    bit          sawDone;
    logic [14:0] expSig;
    expSig     = modelSig();
    cyc        = 1;
    beats      = 0;
    stalls     = 0;
    beat2Stall = 0;
    sawDone    = 1'b0;
    @(posedge clk);
    #1;
    golden    = gold;
    start     = 1'b1;
    rsp_ready = (readyMode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!sawDone && cyc < 400) begin
      @(negedge clk);
      if (cyc == 1) checkOutput({name, ":busyAfterStart"}, 32'(busy), 32'd1);
      if (rsp_valid) begin
        if (beats < NV) begin
          checkOutput({name, ":beatVec"}, 32'(rsp_vec), 32'(beats));
          checkOutput({name, ":beatData"}, 32'(rsp_data), 32'(fTable[beats]));
          checkOutput({name, ":xHeld"}, 32'(x), 32'(beats));
        end else begin
          checkOutput({name, ":extraBeat"}, 32'(beats), 32'(NV - 1));
        end
        if (rsp_ready) begin
          beats++;
        end else begin
          stalls++;
          if (beats == 2) beat2Stall++;
        end
      end
      if (done) begin
        sawDone = 1'b1;
        checkOutput({name, ":doneCycle"}, 32'(cyc), 32'(NV * (S0 + 2) + 1 + stalls));
        checkOutput({name, ":beatCount"}, 32'(beats), 32'(NV));
        checkOutput({name, ":signature"}, 32'(signature), 32'(expSig));
      end else begin
        @(posedge clk);
        cyc++;
        #1;
        start = midStart && (cyc == 10);
        case (readyMode)
          1:       rsp_ready = ($urandom_range(0, 3) != 0);
          2:       rsp_ready = !(rsp_valid && beats == 2 && beat2Stall < 5);
          default: rsp_ready = 1'b1;
        endcase
      end
    end
    if (!sawDone) checkOutput({name, ":timeout"}, 32'(cyc), 32'd0);
    if (readyMode == 2) checkOutput({name, ":beat2Stalls"}, 32'(beat2Stall), 32'd5);
    @(posedge clk);
    #1;
    start     = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput({name, ":pass"}, 32'(pass), 32'(expSig == gold));
    checkOutput({name, ":busyAfterDone"}, 32'(busy), 32'd0);
    checkOutput({name, ":doneOnePulse"}, 32'(done), 32'd0);
    checkOutput({name, ":sigHeld"}, 32'(signature), 32'(expSig));
  endtask

  // Start a sweep, then pull reset once beat 3 is on the interface
  task automatic resetMidSweep();
    int cyc;
    int doneSeen;
    cyc      = 0;
    doneSeen = 0;
    for (int i = 0; i < NV; i++) fTable[i] = 15'(i * 3 + 1);
    @(posedge clk);
    #1;
    start     = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(rsp_valid && rsp_vec == 3'd3) && cyc < 100);
    checkOutput("rstMid:reachedBeat3", 32'(rsp_valid && rsp_vec == 3'd3), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstMid:x", 32'(x), 32'd0);
    checkOutput("rstMid:rspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstMid:rspVec", 32'(rsp_vec), 32'd0);
    checkOutput("rstMid:rspData", 32'(rsp_data), 32'd0);
    checkOutput("rstMid:signature", 32'(signature), 32'd0);
    checkOutput("rstMid:busy", 32'(busy), 32'd0);
    checkOutput("rstMid:pass", 32'(pass), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("rstMid:noDone", 32'(doneSeen), 32'd0);
    checkOutput("rstMid:idleBusy", 32'(busy), 32'd0);
  endtask

  // Sweep the SETTLE=1 instance with loopback responses and the sink always ready
  task automatic settleOneSweep();
    int          cyc;
    int          beats;
    bit          sawDone;
    logic [14:0] expSig;
    for (int i = 0; i < NV; i++) fTable[i] = 15'(i);
    expSig  = modelSig();
    cyc     = 1;
    beats   = 0;
    sawDone = 1'b0;
    @(posedge clk);
    #1;
    start1     = 1'b1;
    rsp_ready1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    while (!sawDone && cyc < 200) begin
      @(negedge clk);
      if (rsp_valid1 && rsp_ready1) begin
        checkOutput("settle1:beatVec", 32'(rsp_vec1), 32'(beats));
        checkOutput("settle1:loopback", 32'(rsp_data1), 32'(beats));
        beats++;
      end
      if (done1) begin
        sawDone = 1'b1;
        checkOutput("settle1:doneCycle", 32'(cyc), 32'(NV * (S1 + 2) + 1));
        checkOutput("settle1:beatCount", 32'(beats), 32'(NV));
        checkOutput("settle1:signature", 32'(signature1), 32'(expSig));
      end else begin
        @(posedge clk);
        cyc++;
        #1;
      end
    end
    if (!sawDone) checkOutput("settle1:timeout", 32'(cyc), 32'd0);
    @(negedge clk);
    checkOutput("settle1:pass", 32'(pass1), 32'(expSig == 15'h0000));
  endtask

  // Test sequence
  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    start1     = 1'b0;
    golden     = '0;
    rsp_ready  = 1'b0;
    rsp_ready1 = 1'b0;
    for (int i = 0; i < NV; i++) fTable[i] = '0;
    #12;
    checkOutput("reset:x", 32'(x), 32'd0);
    checkOutput("reset:rspValid", 32'(rsp_valid), 32'd0);
    checkOutput("reset:busy", 32'(busy), 32'd0);
    checkOutput("reset:done", 32'(done), 32'd0);
    checkOutput("reset:pass", 32'(pass), 32'd0);
    checkOutput("reset:signature", 32'(signature), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] zero response sweep");
    applyStimulus("zero", 0, 15'h0000, 1'b0);

    $display("[TB] constant-one response sweeps");
    for (int i = 0; i < NV; i++) fTable[i] = 15'h0001;
    applyStimulus("ones", 0, 15'h00FF, 1'b0);
    applyStimulus("onesBadGold", 0, 15'h00FE, 1'b0);

    $display("[TB] backpressure on beat 2");
    for (int i = 0; i < NV; i++) fTable[i] = 15'($urandom);
    applyStimulus("stall", 2, 15'h1234, 1'b0);

    $display("[TB] loopback with start while busy");
    for (int i = 0; i < NV; i++) fTable[i] = 15'(i);
    applyStimulus("loop", 0, 15'h0000, 1'b1);

    $display("[TB] random responses and random sink");
    for (int r = 0; r < 5; r++) begin
      logic [14:0] gold;
      for (int i = 0; i < NV; i++) fTable[i] = 15'($urandom);
      gold = ($urandom_range(0, 1) == 1) ? modelSig() : 15'($urandom);
      applyStimulus("rand", 1, gold, r[0]);
    end

    $display("[TB] reset during a sweep");
    resetMidSweep();

    $display("[TB] SETTLE=1 instance");
    settleOneSweep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
